mem_port_arbiter: RTL and testbench

Shares a single fixed-latency, unified instruction/data memory port between the fetch stage (IF) and the memory stage (MEM) of the pipelined RV32I core. It serializes accesses, issues one registered memory command per transaction, and returns read data with a one-cycle ready pulse. It also generates the stall signals the hazard logic needs to freeze the pipeline while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one fixed-latency memory port between instruction fetch and data access.
// Issues one registered command per transaction and returns data with a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wmask,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_last_grant;   // 0 = fetch won last tie-relevant grant, 1 = data
    logic          r_mem_en;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wmask;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (if_req && (!dm_req || r_last_grant)) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = BUSY_I;
                end else if (dm_req) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_cnt_zero) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_en <= w_grant_i | w_grant_d;
            if (w_grant_i) begin
                r_cnt        <= CW'(MEM_LAT);
                r_last_grant <= 1'b0;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= if_addr;
                r_mem_wdata  <= '0;
                r_mem_wmask  <= '0;
            end else if (w_grant_d) begin
                r_cnt        <= CW'(MEM_LAT);
                r_last_grant <= 1'b1;
                r_mem_we     <= dm_we;
                r_mem_addr   <= dm_addr;
                r_mem_wdata  <= dm_wdata;
                r_mem_wmask  <= dm_we ? dm_wmask : 4'h0;
            end else if (r_state != IDLE && !w_cnt_zero) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign if_ready  = (r_state == BUSY_I) && w_cnt_zero;
    assign dm_ready  = (r_state == BUSY_D) && w_cnt_zero;
    assign if_rdata  = if_ready ? mem_rdata : 32'h0;
    assign dm_rdata  = dm_ready ? mem_rdata : 32'h0;
    assign stall_f   = if_req & ~if_ready;
    assign stall_m   = dm_req & ~dm_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model checks the MEM_LAT=2 instance every cycle,
// directed vectors pin literal values, and a MEM_LAT=1 instance covers back-to-back loads.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        stall_f;
    logic        stall_m;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    // Second instance with MEM_LAT=1.
    logic        d1_if_req;
    logic [31:0] d1_if_addr;
    logic        d1_dm_req;
    logic [31:0] d1_dm_addr;
    logic [31:0] d1_mem_rdata;
    logic [31:0] d1_if_rdata;
    logic        d1_if_ready;
    logic [31:0] d1_dm_rdata;
    logic        d1_dm_ready;
    logic        d1_stall_f;
    logic        d1_stall_m;
    logic        d1_mem_en;
    logic        d1_mem_we;
    logic [31:0] d1_mem_addr;
    logic [31:0] d1_mem_wdata;
    logic [3:0]  d1_mem_wmask;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(d1_if_req), .if_addr(d1_if_addr), .if_rdata(d1_if_rdata), .if_ready(d1_if_ready),
        .dm_req(d1_dm_req), .dm_we(1'b0), .dm_addr(d1_dm_addr), .dm_wdata(32'h0),
        .dm_wmask(4'h0), .dm_rdata(d1_dm_rdata), .dm_ready(d1_dm_ready),
        .stall_f(d1_stall_f), .stall_m(d1_stall_m),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_wmask(d1_mem_wmask), .mem_rdata(d1_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: one known instruction, everything else derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Fixed-latency memories; drive filler data whenever no read is due.
    logic        v0, v1, w0;
    logic [31:0] a0, a1, b0;
    always @(posedge clk) begin
        v0 <= mem_en;
        a0 <= mem_addr;
        v1 <= v0;
        a1 <= a0;
        w0 <= d1_mem_en;
        b0 <= d1_mem_addr;
    end
    assign mem_rdata    = (v1 === 1'b1) ? mem_word(a1) : 32'h5A5A5A5A;
    assign d1_mem_rdata = (w0 === 1'b1) ? mem_word(b0) : 32'h5A5A5A5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: one access at a time, identified by the cycle its command issues.
    int          cyc = 0;
    bit          checking = 1'b0;
    bit          m_active = 1'b0;
    bit          m_is_d = 1'b0;
    bit          m_last_d = 1'b0;
    int          m_issue = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wmask = '0;
    logic        m_we = 1'b0;

    always @(posedge clk) begin
        bit pick_d;
        if (reset) begin
            checking <= 1'b1;
            m_active <= 1'b0;
            m_last_d <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_wmask  <= '0;
            m_we     <= 1'b0;
        end else if (m_active && cyc == m_issue + LAT) begin
            m_active <= 1'b0;
        end else if (!m_active && (if_req || dm_req)) begin
            pick_d = dm_req && (!if_req || !m_last_d);
            m_active <= 1'b1;
            m_is_d   <= pick_d;
            m_last_d <= pick_d;
            m_issue  <= cyc + 1;
            m_addr   <= pick_d ? dm_addr : if_addr;
            m_we     <= pick_d && dm_we;
            m_wdata  <= dm_wdata;
            m_wmask  <= (pick_d && dm_we) ? dm_wmask : 4'h0;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        bit e_en, e_rdy, e_if, e_dm;
        if (checking) begin
            e_en  = m_active && (cyc == m_issue);
            e_rdy = m_active && (cyc == m_issue + LAT);
            e_if  = e_rdy && !m_is_d;
            e_dm  = e_rdy && m_is_d;
            check("mdl_mem_en", {31'h0, mem_en}, {31'h0, e_en});
            check("mdl_mem_addr", mem_addr, m_addr);
            check("mdl_mem_wmask", {28'h0, mem_wmask}, {28'h0, m_wmask});
            if (e_en) check("mdl_mem_we", {31'h0, mem_we}, {31'h0, m_we});
            if (e_en && m_we) check("mdl_mem_wdata", mem_wdata, m_wdata);
            check("mdl_if_ready", {31'h0, if_ready}, {31'h0, e_if});
            check("mdl_dm_ready", {31'h0, dm_ready}, {31'h0, e_dm});
            check("mdl_if_rdata", if_rdata, e_if ? mem_word(m_addr) : 32'h0);
            check("mdl_dm_rdata", dm_rdata, e_dm ? mem_word(m_addr) : 32'h0);
            check("mdl_stall_f", {31'h0, stall_f}, {31'h0, if_req & ~e_if});
            check("mdl_stall_m", {31'h0, stall_m}, {31'h0, dm_req & ~e_dm});
        end
    end

    // Start a new cycle (inputs change just after the edge) / move to the mid-cycle sample point.
    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic ne();
        @(negedge clk);
    endtask

    int order[$];
    int exp_order[4] = '{3 * 2 + 1, 7 * 2, 11 * 2 + 1, 15 * 2};

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wmask = '0;
        d1_if_req = 1'b0; d1_if_addr = '0; d1_dm_req = 1'b0; d1_dm_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ne();
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_ready", {31'h0, dm_ready}, 32'h0);

        // Fetch from 0x100.
        nc(); if_req = 1'b1; if_addr = 32'h100; ne();
        check("f_c0_stall_f", {31'h0, stall_f}, 32'h1);
        nc(); ne();
        check("f_c1_mem_en", {31'h0, mem_en}, 32'h1);
        check("f_c1_mem_addr", mem_addr, 32'h100);
        check("f_c1_mem_we", {31'h0, mem_we}, 32'h0);
        nc(); ne();
        check("f_c2_stall_f", {31'h0, stall_f}, 32'h1);
        nc(); ne();
        check("f_c3_if_ready", {31'h0, if_ready}, 32'h1);
        check("f_c3_if_rdata", if_rdata, 32'h00500093);
        check("f_c3_stall_f", {31'h0, stall_f}, 32'h0);
        nc(); if_req = 1'b0; ne();

        // Full-word store.
        nc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_wmask = 4'hF; ne();
        nc(); ne();
        check("s_c1_mem_we", {31'h0, mem_we}, 32'h1);
        check("s_c1_mem_wmask", {28'h0, mem_wmask}, 32'hF);
        check("s_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        nc(); ne();
        nc(); ne();
        check("s_c3_dm_ready", {31'h0, dm_ready}, 32'h1);
        check("s_c3_if_ready", {31'h0, if_ready}, 32'h0);
        nc(); dm_req = 1'b0; dm_we = 1'b0; ne();

        // Tie right after reset: data first, then fetch; load masks are forced to zero.
        nc(); reset = 1'b1; ne();
        nc(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_addr = 32'h3000; dm_wmask = 4'hF; ne();
        nc(); ne();
        check("t_c1_mem_addr", mem_addr, 32'h3000);
        check("t_c1_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        nc(); ne();
        nc(); ne();
        check("t_c3_dm_ready", {31'h0, dm_ready}, 32'h1);
        check("t_c3_dm_rdata", dm_rdata, 32'h3000CFFF);
        check("t_c3_stall_f", {31'h0, stall_f}, 32'h1);
        nc(); dm_req = 1'b0; ne();
        nc(); ne();
        check("t_c5_mem_en", {31'h0, mem_en}, 32'h1);
        check("t_c5_mem_addr", mem_addr, 32'h200);
        nc(); ne();
        nc(); ne();
        check("t_c7_if_rdata", if_rdata, 32'h0200FDFF);
        nc(); if_req = 1'b0; ne();

        // Both held for four transactions: D, I, D, I with ready pulses 4 cycles apart.
        nc(); if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_addr = 32'h4000;
        for (int i = 0; i < 16; i++) begin
            ne();
            if (dm_ready) order.push_back(i * 2 + 1);
            if (if_ready) order.push_back(i * 2);
            if (i < 15) nc();
        end
        check("fair_count", order.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("fair_pulse%0d", k), (k < order.size()) ? order[k] : -1, exp_order[k]);
        nc(); if_req = 1'b0; dm_req = 1'b0; ne();

        // MEM_LAT=1 back-to-back loads.
        nc(); d1_dm_req = 1'b1; d1_dm_addr = 32'h10; ne();
        nc(); ne();
        check("l1_c1_mem_en", {31'h0, d1_mem_en}, 32'h1);
        check("l1_c1_mem_addr", d1_mem_addr, 32'h10);
        nc(); ne();
        check("l1_c2_dm_ready", {31'h0, d1_dm_ready}, 32'h1);
        check("l1_c2_dm_rdata", d1_dm_rdata, 32'h0010FFEF);
        nc(); d1_dm_addr = 32'h14; ne();
        check("l1_c3_mem_en", {31'h0, d1_mem_en}, 32'h0);
        check("l1_c3_dm_ready", {31'h0, d1_dm_ready}, 32'h0);
        nc(); ne();
        check("l1_c4_mem_en", {31'h0, d1_mem_en}, 32'h1);
        check("l1_c4_mem_addr", d1_mem_addr, 32'h14);
        nc(); ne();
        check("l1_c5_dm_ready", {31'h0, d1_dm_ready}, 32'h1);
        check("l1_c5_dm_rdata", d1_dm_rdata, 32'h0014FFEB);
        nc(); d1_dm_req = 1'b0; ne();

        // Reset while a fetch is outstanding.
        nc(); if_req = 1'b1; if_addr = 32'h400; ne();
        nc(); ne();
        check("r_c1_mem_en", {31'h0, mem_en}, 32'h1);
        nc(); reset = 1'b1; ne();
        nc(); reset = 1'b0; ne();
        check("r_c3_if_ready", {31'h0, if_ready}, 32'h0);
        check("r_c3_if_rdata", if_rdata, 32'h0);
        check("r_c3_mem_addr", mem_addr, 32'h0);
        check("r_c3_stall_f", {31'h0, stall_f}, 32'h1);
        nc(); ne();
        check("r_c4_mem_en", {31'h0, mem_en}, 32'h1);
        check("r_c4_mem_addr", mem_addr, 32'h400);
        nc(); ne();
        nc(); ne();
        check("r_c6_if_rdata", if_rdata, 32'h0400FBFF);
        nc(); if_req = 1'b0; ne();

        repeat (3) nc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
